sipo_collector: RTL and testbench
=================================

Name: sipo_collector

Overview:
Serial-in, parallel-out collector. It is the receive-side counterpart of the parallel-to-serial chunk shifter. It accepts a stream of WIDTH-bit chunks, most-significant chunk first, and reassembles each group of DEPTH chunks into one DEPTH*WIDTH-bit word for a parallel consumer. It holds one assembled word in a shift register and one in an output register, and drives `halt` upstream so the serializer stalls instead of losing data.

Parameters:
DEPTH, 8, chunks per assembled word (≥2)
WIDTH, 8, bits per chunk

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
si  input  WIDTH  serial chunk in
si_dv  input  1  si valid this cycle
halt  output  1  stall request to upstream serializer (registered)
po  output  DEPTH*WIDTH  assembled word
po_dv  output  1  po holds an unread word
po_rd  input  1  consumer accepts po this cycle (ignored when po_dv=0)
clr  input  1  synchronous flush / resync
busy  output  1  partial word in progress (cnt≠0)
ovf  output  1  sticky: chunk arrived while halt=1 and was dropped

Behaviour:
- Reset (rst_n=0, async): po=0, po_dv=0, halt=0, ovf=0, busy=0; internal sr=0, cnt=0, state=FILL.
- Chunk order: the first chunk of a word lands in po[DEPTH*WIDTH-1 -: WIDTH]; the last chunk lands in po[WIDTH-1:0].
- Shift rule on an accepted chunk: sr <= {sr[(DEPTH-1)*WIDTH-1:0], si}.
- Internal state: sr (DEPTH*WIDTH), cnt (0..DEPTH-1, width clog2(DEPTH)), FSM {FILL, HOLD}.
- halt = (state==HOLD), registered, no combinational path from any input.
- FILL:
  - si_dv=1 and cnt<DEPTH-1: shift in, cnt++.
  - si_dv=1 and cnt==DEPTH-1, with the output register free (po_dv=0, or po_rd=1 this cycle):
    - po <= completed word, po_dv <= 1, cnt <= 0.
    - One-cycle latency: po_dv rises on the edge that captures the last chunk.
  - si_dv=1 and cnt==DEPTH-1, with the output register occupied and not read:
    - sr <= completed word, cnt <= 0, state <= HOLD; halt rises next cycle.
  - si_dv=0: no change to sr or cnt.
- HOLD:
  - si_dv=1: chunk dropped, ovf <= 1, sr unchanged.
  - po_rd=1: po <= sr, po_dv stays 1, state <= FILL; halt falls next cycle.
  - Simultaneous po_rd and si_dv in HOLD: the transfer happens and the chunk is still dropped with ovf set. The chunk is not captured.
- po_rd in FILL with po_dv=1 and no word completing: po_dv <= 0; po value retained.
- po_rd while po_dv=0: ignored.
- clr=1 (priority over all other inputs except rst_n):
  - cnt=0, sr=0, state=FILL, po_dv=0, ovf=0.
  - po retains its last value; any partial or held word is discarded.
- rst_n asserted mid-word: all state returns to reset values immediately; no partial word survives.
- busy = (cnt≠0), registered from cnt.
- Back-to-back: a continuous si_dv stream with po_rd asserted every word yields one po_dv pulse per DEPTH chunks and halt never asserts.

Test Plan:
- Use DEPTH=4, WIDTH=8 for all scenarios.
- Basic assembly: si=0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles with si_dv=1 → po=0xAABBCCDD and po_dv=1 the cycle after 0xDD; busy=1 after the first chunk and 0 after the fourth.
- Gaps: same four chunks with si_dv=0 idle cycles between them → identical po; cnt does not advance on idle cycles.
- Back-pressure:
  - Stimulus: word 0x11223344, then word 0x55667788 with po_rd=0 throughout.
  - Required: halt=1 after the 8th chunk; po still 0x11223344.
  - Then pulse po_rd → next cycle po=0x55667788, po_dv=1, halt=0.
- Overrun: while halt=1, present si=0x99 with si_dv=1 → ovf=1 and sr unchanged. After po_rd, the next 4 chunks 0x01..0x04 → po=0x01020304.
- Flush: after 2 chunks (0xAA, 0xBB), pulse clr, then send 0x10,0x20,0x30,0x40 → po=0x10203040, and ovf, busy and halt are all 0.
- Async reset mid-word: drop rst_n between clock edges after 3 chunks → po_dv, halt, busy and ovf all go 0 without waiting for a clock edge. The next 4 chunks assemble correctly.

Source files
------------

// File: rtl/sipo_collector.sv
// Serial-in, parallel-out collector: packs DEPTH chunks (MS chunk first) into one word,
// double-buffered through sr/po, and stalls the upstream serializer with halt when both are full.
module sipo_collector #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         si,
   input  logic                     si_dv,
   output logic                     halt,
   output logic [DEPTH*WIDTH-1:0]   po,
   output logic                     po_dv,
   input  logic                     po_rd,
   input  logic                     clr,
   output logic                     busy,
   output logic                     ovf
);

   localparam int            W    = DEPTH * WIDTH;
   localparam int            CW   = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t          r_state, w_state_n;
   logic [W-1:0]    r_sr, w_sr_n;
   logic [CW-1:0]   r_cnt, w_cnt_n;
   logic [W-1:0]    r_po, w_po_n;
   logic            r_po_dv, w_po_dv_n;
   logic            r_ovf, w_ovf_n;
   logic            r_halt, r_busy;
   logic [W-1:0]    w_word;

   assign w_word = {r_sr[W-WIDTH-1:0], si};

   always_comb begin
      w_state_n = r_state;
      w_sr_n    = r_sr;
      w_cnt_n   = r_cnt;
      w_po_n    = r_po;
      w_po_dv_n = r_po_dv;
      w_ovf_n   = r_ovf;
      if (clr) begin
         // po keeps its last value; everything in flight is discarded
         w_state_n = FILL;
         w_sr_n    = '0;
         w_cnt_n   = '0;
         w_po_dv_n = 1'b0;
         w_ovf_n   = 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (po_rd && r_po_dv) w_po_dv_n = 1'b0;
               if (si_dv) begin
                  w_sr_n = w_word;
                  if (r_cnt != LAST) begin
                     w_cnt_n = r_cnt + CW'(1);
                  end else if (!r_po_dv || po_rd) begin
                     w_po_n    = w_word;
                     w_po_dv_n = 1'b1;
                     w_cnt_n   = '0;
                  end else begin
                     w_cnt_n   = '0;
                     w_state_n = HOLD;
                  end
               end
            end
            HOLD: begin
               // incoming chunks are lost while stalled, even on the release cycle
               if (si_dv) w_ovf_n = 1'b1;
               if (po_rd) begin
                  w_po_n    = r_sr;
                  w_state_n = FILL;
               end
            end
            default: w_state_n = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_po    <= '0;
         r_po_dv <= 1'b0;
         r_ovf   <= 1'b0;
         r_halt  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_sr    <= w_sr_n;
         r_cnt   <= w_cnt_n;
         r_po    <= w_po_n;
         r_po_dv <= w_po_dv_n;
         r_ovf   <= w_ovf_n;
         r_halt  <= (w_state_n == HOLD);
         r_busy  <= (w_cnt_n != '0);
      end
   end

   assign halt  = r_halt;
   assign po    = r_po;
   assign po_dv = r_po_dv;
   assign busy  = r_busy;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector at DEPTH=4, WIDTH=8 with hand-computed expectations.
module tb_sipo_collector;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic                   clk;
   logic                   rst_n;
   logic [WIDTH-1:0]       si;
   logic                   si_dv;
   logic                   halt;
   logic [DEPTH*WIDTH-1:0] po;
   logic                   po_dv;
   logic                   po_rd;
   logic                   clr;
   logic                   busy;
   logic                   ovf;

   int n_vec;
   int n_err;

   sipo_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .si    (si),
      .si_dv (si_dv),
      .halt  (halt),
      .po    (po),
      .po_dv (po_dv),
      .po_rd (po_rd),
      .clr   (clr),
      .busy  (busy),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are set just after an edge and outputs sampled 1 time unit after the next one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chunk(input logic [7:0] d);
      si    = d;
      si_dv = 1'b1;
      tick();
      si_dv = 1'b0;
   endtask

   task automatic read_out();
      po_rd = 1'b1;
      tick();
      po_rd = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_vec++; if (po !== 32'h0)  begin n_err++; $display("FAIL reset_po got %h want 0", po); end
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL reset_po_dv got %b want 0", po_dv); end
      n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b want 0", halt); end
      n_vec++; if (ovf !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      chunk(8'hAA);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy1 got %b want 1", busy); end
      chunk(8'hBB);
      chunk(8'hCC);
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL basic_early_dv got %b want 0", po_dv); end
      chunk(8'hDD);
      n_vec++; if (po !== 32'hAABBCCDD) begin n_err++; $display("FAIL basic_po got %h want aabbccdd", po); end
      n_vec++; if (po_dv !== 1'b1) begin n_err++; $display("FAIL basic_dv got %b want 1", po_dv); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy0 got %b want 0", busy); end
      read_out();
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL basic_rd_dv got %b want 0", po_dv); end
      n_vec++; if (po !== 32'hAABBCCDD) begin n_err++; $display("FAIL basic_rd_po got %h want aabbccdd", po); end
   endtask

   task automatic test_gaps();
      chunk(8'hAA); tick(); tick();
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL gaps_busy got %b want 1", busy); end
      chunk(8'hBB); tick();
      chunk(8'hCC); tick(); tick(); tick();
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL gaps_early_dv got %b want 0", po_dv); end
      chunk(8'hDD);
      n_vec++; if (po !== 32'hAABBCCDD) begin n_err++; $display("FAIL gaps_po got %h want aabbccdd", po); end
      n_vec++; if (po_dv !== 1'b1) begin n_err++; $display("FAIL gaps_dv got %b want 1", po_dv); end
      read_out();
   endtask

   task automatic test_backpressure();
      chunk(8'h11); chunk(8'h22); chunk(8'h33); chunk(8'h44);
      n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL bp_halt_early got %b want 0", halt); end
      chunk(8'h55); chunk(8'h66); chunk(8'h77); chunk(8'h88);
      n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL bp_halt got %b want 1", halt); end
      n_vec++; if (po !== 32'h11223344) begin n_err++; $display("FAIL bp_po_held got %h want 11223344", po); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy got %b want 0", busy); end
      // overrun while stalled
      chunk(8'h99);
      n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovr_ovf got %b want 1", ovf); end
      n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL ovr_halt got %b want 1", halt); end
      read_out();
      n_vec++; if (po !== 32'h55667788) begin n_err++; $display("FAIL bp_po_next got %h want 55667788", po); end
      n_vec++; if (po_dv !== 1'b1) begin n_err++; $display("FAIL bp_dv got %b want 1", po_dv); end
      n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL bp_halt_fall got %b want 0", halt); end
      read_out();
      chunk(8'h01); chunk(8'h02); chunk(8'h03); chunk(8'h04);
      n_vec++; if (po !== 32'h01020304) begin n_err++; $display("FAIL ovr_po got %h want 01020304", po); end
      n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got %b want 1", ovf); end
   endtask

   task automatic test_flush();
      // po_dv=1 with 0x01020304 unread, ovf=1 at entry
      chunk(8'hAA); chunk(8'hBB);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL flush_ovf got %b want 0", ovf); end
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL flush_dv got %b want 0", po_dv); end
      n_vec++; if (po !== 32'h01020304) begin n_err++; $display("FAIL flush_po_kept got %h want 01020304", po); end
      chunk(8'h10); chunk(8'h20); chunk(8'h30); chunk(8'h40);
      n_vec++; if (po !== 32'h10203040) begin n_err++; $display("FAIL flush_po got %h want 10203040", po); end
      n_vec++; if (po_dv !== 1'b1) begin n_err++; $display("FAIL flush_po_dv got %b want 1", po_dv); end
      n_vec++; if ({ovf, busy, halt} !== 3'b000) begin n_err++; $display("FAIL flush_flags got %b want 000", {ovf, busy, halt}); end
   endtask

   task automatic test_hold_collision();
      // po still occupied by 0x10203040, so this word parks in sr
      chunk(8'hC0); chunk(8'hC1); chunk(8'hC2); chunk(8'hC3);
      n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL coll_halt got %b want 1", halt); end
      si    = 8'hEE;
      si_dv = 1'b1;
      po_rd = 1'b1;
      tick();
      si_dv = 1'b0;
      po_rd = 1'b0;
      n_vec++; if (po !== 32'hC0C1C2C3) begin n_err++; $display("FAIL coll_po got %h want c0c1c2c3", po); end
      n_vec++; if ({po_dv, halt, ovf, busy} !== 4'b1010) begin n_err++; $display("FAIL coll_flags got %b want 1010", {po_dv, halt, ovf, busy}); end
      read_out();
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL coll_rd_dv got %b want 0", po_dv); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w;
      int          pulses;
      pulses = 0;
      exp_w  = '0;
      po_rd  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         si    = 8'(8'h40 + k);
         si_dv = 1'b1;
         exp_w = {exp_w[23:0], 8'(8'h40 + k)};
         tick();
         n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL b2b_halt k=%0d got %b want 0", k, halt); end
         n_vec++; if (po_dv !== ((k % 4) == 3)) begin n_err++; $display("FAIL b2b_dv k=%0d got %b want %b", k, po_dv, ((k % 4) == 3)); end
         if (po_dv === 1'b1) begin
            pulses++;
            n_vec++; if (po !== exp_w) begin n_err++; $display("FAIL b2b_po k=%0d got %h want %h", k, po, exp_w); end
         end
      end
      si_dv = 1'b0;
      tick();
      po_rd = 1'b0;
      n_vec++; if (pulses != 3) begin n_err++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
      n_vec++; if (po_dv !== 1'b0) begin n_err++; $display("FAIL b2b_final_dv got %b want 0", po_dv); end
   endtask

   task automatic test_async_reset();
      chunk(8'hD0); chunk(8'hD1); chunk(8'hD2); chunk(8'hD3);
      chunk(8'hA1); chunk(8'hA2); chunk(8'hA3);
      n_vec++; if ({po_dv, busy} !== 2'b11) begin n_err++; $display("FAIL arst_pre got %b want 11", {po_dv, busy}); end
      // mid-cycle, well away from any clock edge
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({po_dv, halt, busy, ovf} !== 4'b0000) begin n_err++; $display("FAIL arst_flags got %b want 0000", {po_dv, halt, busy, ovf}); end
      n_vec++; if (po !== 32'h0) begin n_err++; $display("FAIL arst_po got %h want 0", po); end
      rst_n = 1'b1;
      chunk(8'h0A); chunk(8'h0B); chunk(8'h0C); chunk(8'h0D);
      n_vec++; if (po !== 32'h0A0B0C0D) begin n_err++; $display("FAIL arst_po_after got %h want 0a0b0c0d", po); end
      n_vec++; if (po_dv !== 1'b1) begin n_err++; $display("FAIL arst_dv_after got %b want 1", po_dv); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      si    = '0;
      si_dv = 1'b0;
      po_rd = 1'b0;
      clr   = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_backpressure();
      test_flush();
      test_hold_collision();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
